// File: rtl/pb_event_gen.sv
// pb_event_gen: turns a debounced button level into press, release, long-press
// and auto-repeat pulses, and reports how long the current or last hold lasted in ms.
module pb_event_gen #(
    parameter int LONG_MS          = 500,
    parameter int REPEAT_DELAY_MS  = 500,
    parameter int REPEAT_PERIOD_MS = 100,
    parameter bit REPEAT_EN        = 1'b1,
    parameter int CNT_W            = 10
) (
    input  logic             clk_1ms,
    input  logic             rst,
    input  logic             pb_level,
    output logic             press_pulse,
    output logic             release_pulse,
    output logic             long_press,
    output logic             repeat_pulse,
    output logic             held,
    output logic [CNT_W-1:0] hold_ms
);
    localparam int MX = (REPEAT_DELAY_MS > REPEAT_PERIOD_MS) ? REPEAT_DELAY_MS : REPEAT_PERIOD_MS;
    localparam int RW = $clog2(MX + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LONG_V   = CNT_W'(LONG_MS);
    localparam logic [RW-1:0]    DELAY_V  = RW'(REPEAT_DELAY_MS);
    localparam logic [RW-1:0]    PERIOD_V = RW'(REPEAT_PERIOD_MS);

    typedef enum logic [1:0] {IDLE, HELD, REPEAT} state_t;

    state_t           state_q, state_d;
    logic             pb_q;
    logic [CNT_W-1:0] hold_q, hold_d, hold_inc;
    logic [RW-1:0]    rep_q, rep_d, rep_inc;
    logic             press_q, press_d, release_q, release_d;
    logic             long_q, long_d, repeat_q, repeat_d;
    logic             e0, cnt, rel, tick, rep_hit, long_hit;

    // pb_q resets high so a button held through reset must be released before it can press
    always_ff @(posedge clk_1ms) begin
        if (rst) begin
            state_q   <= IDLE;
            pb_q      <= 1'b1;
            hold_q    <= '0;
            rep_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pb_q      <= pb_level;
            hold_q    <= hold_d;
            rep_q     <= rep_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
        end
    end

    always_comb begin
        e0       = (state_q == IDLE) && pb_level && !pb_q;
        cnt      = (state_q != IDLE) && pb_level;
        rel      = (state_q != IDLE) && !pb_level;
        tick     = e0 || cnt;
        hold_inc = e0 ? CNT_W'(1) : (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        rep_inc  = e0 ? RW'(1) : rep_q + 1'b1;
        rep_hit  = REPEAT_EN && tick && (rep_inc == ((state_q == REPEAT) ? PERIOD_V : DELAY_V));
        // a saturated hold_ms equal to LONG_MS must not retrigger, so require a change
        long_hit = tick && (hold_inc == LONG_V) && (e0 || hold_q != LONG_V);
        state_d  = rel ? IDLE : rep_hit ? REPEAT : e0 ? HELD : state_q;
        hold_d   = tick ? hold_inc : hold_q;
        rep_d    = rep_hit ? '0 : tick ? rep_inc : rep_q;
    end

    always_comb begin
        press_d   = e0;
        release_d = rel;
        long_d    = long_hit;
        repeat_d  = rep_hit;
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_press    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = state_q != IDLE;
    assign hold_ms       = hold_q;
endmodule

// File: tb/tb_pb_event_gen.sv
// tb_pb_event_gen: drives a default and a narrow-counter instance with directed and
// random button holds, checking every cycle against a hold-length arithmetic model.
module tb_pb_event_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pb  = 1'b1;
    always #5 clk = ~clk;

    logic       p0, r0, l0, q0, h0;
    logic [9:0] m0;
    logic       p1, r1, l1, q1, h1;
    logic [3:0] m1;

    pb_event_gen u_def (
        .clk_1ms(clk), .rst(rst), .pb_level(pb),
        .press_pulse(p0), .release_pulse(r0), .long_press(l0),
        .repeat_pulse(q0), .held(h0), .hold_ms(m0)
    );

    pb_event_gen #(.LONG_MS(10), .REPEAT_DELAY_MS(12), .REPEAT_PERIOD_MS(3), .CNT_W(4)) u_small (
        .clk_1ms(clk), .rst(rst), .pb_level(pb),
        .press_pulse(p1), .release_pulse(r1), .long_press(l1),
        .repeat_pulse(q1), .held(h1), .hold_ms(m1)
    );

    int pl[2]   = '{500, 10};
    int pd[2]   = '{500, 12};
    int pp[2]   = '{100, 3};
    int pmax[2] = '{1023, 15};

    int   m_h[2], m_ho[2];
    logic m_in[2], m_pbq[2];
    logic [14:0] sb0[$], sb1[$];
    int compared = 0, mismatched = 0;

    // expected vector: {press, release, long, repeat, held, hold_ms}
    function automatic logic [14:0] model(input int i, input logic r, input logic p);
        logic pr, rl, lg, rp;
        pr = 0; rl = 0; lg = 0; rp = 0;
        if (r) begin
            m_in[i] = 0; m_pbq[i] = 1; m_ho[i] = 0; m_h[i] = 0;
        end else begin
            if (!m_in[i]) begin
                if (p && !m_pbq[i]) begin m_in[i] = 1; m_h[i] = 1; pr = 1; end
            end else if (p) m_h[i]++;
            else begin rl = 1; m_in[i] = 0; end
            if (m_in[i]) begin
                lg = (m_h[i] == pl[i]);
                rp = (m_h[i] >= pd[i]) && ((m_h[i] - pd[i]) % pp[i] == 0);
                m_ho[i] = (m_h[i] > pmax[i]) ? pmax[i] : m_h[i];
            end
            m_pbq[i] = p;
        end
        return {pr, rl, lg, rp, m_in[i], 10'(m_ho[i])};
    endfunction

    task automatic step(input logic r, input logic p);
        @(negedge clk);
        rst = r; pb = p;
        sb0.push_back(model(0, r, p));
        sb1.push_back(model(1, r, p));
    endtask

    task automatic hold(input logic p, input int n);
        repeat (n) step(1'b0, p);
    endtask

    task automatic cmp(input string name, input logic [14:0] act, input logic [14:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s t=%0t got p/r/l/q/h=%b hold=%0d expected p/r/l/q/h=%b hold=%0d",
                     name, $time, act[14:10], act[9:0], exp[14:10], exp[9:0]);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb0.size() > 0) cmp("def", {p0, r0, l0, q0, h0, m0}, sb0.pop_front());
        if (sb1.size() > 0) cmp("small", {p1, r1, l1, q1, h1, 6'b0, m1}, sb1.pop_front());
    end

    initial begin
        repeat (3) step(1'b1, 1'b1);
        hold(1, 20); hold(0, 5);
        hold(1, 50); hold(0, 5);
        hold(1, 800); hold(0, 3);
        hold(1, 499); hold(0, 3);
        hold(1, 30); hold(0, 3);
        hold(1, 200); step(1'b1, 1'b1); step(1'b1, 1'b1);
        hold(1, 10); hold(0, 2); hold(1, 5); hold(0, 2);
        hold(1, 5); hold(0, 1); hold(1, 5); hold(0, 2);
        for (int k = 0; k < 30; k++) begin
            hold(1, $urandom_range(1, 700));
            if ($urandom_range(0, 5) == 0) step(1'b1, $urandom_range(0, 1) == 1);
            hold(0, $urandom_range(1, 4));
        end
        @(posedge clk); #2;
        if (sb0.size() != 0 || sb1.size() != 0) begin
            mismatched++;
            $display("FAIL drain left %0d/%0d expected entries unchecked", sb0.size(), sb1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
